// File: rtl/wb_reg_bank_pkg.sv
// Shared types and helpers for the parametrised Wishbone register bank.
package wb_reg_bank_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;
    localparam int DEC_AW  = 16;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_ACK  = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef struct packed {
        logic              is_rw;
        logic              is_ro;
        logic [DEC_AW-1:0] index;
    } dec_t;

    // RW words sit at the bottom of the map, RO words directly above them.
    function automatic dec_t decode(input logic [DEC_AW-1:0] adr, input int num_rw, input int num_ro);
        dec_t d;
        d.is_rw = 1'b0;
        d.is_ro = 1'b0;
        d.index = {DEC_AW{1'b0}};
        if (int'(adr) < num_rw) begin
            d.is_rw = 1'b1;
            d.index = adr;
        end else if (int'(adr) < num_rw + num_ro) begin
            d.is_ro = 1'b1;
            d.index = adr - DEC_AW'(num_rw);
        end else begin
            d.index = {DEC_AW{1'b0}};
        end
        return d;
    endfunction

    function automatic logic [WB_DW-1:0] byte_merge(input logic [WB_DW-1:0] old_v,
                                                    input logic [WB_DW-1:0] new_v,
                                                    input logic [WB_SELW-1:0] sel);
        logic [WB_DW-1:0] r;
        for (int b = 0; b < WB_SELW; b++) begin
            r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_reg_bank_pipe_slave_if.sv
// Wishbone pipelined slave handshake: one outstanding request, read/write
// pending tracking, single-cycle ack/err pulses gated by wb_cyc_i.
module wb_pipe_slave_if
    import wb_reg_bank_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [1:0] rd_resp,
    input  logic [1:0] wr_resp,
    output logic       rd_req,
    output logic       wr_req,
    output logic       wr_commit,
    output logic       wb_ack_o,
    output logic       wb_err_o,
    output logic       wb_stall_o
);

    logic       rip_r;
    logic       wip_r;
    logic       wr_term_r;
    logic [1:0] resp_r;
    logic       accept_s;

    assign accept_s  = wb_cyc_i & wb_stb_i & ~rip_r & ~wip_r;
    assign rd_req    = accept_s & ~wb_we_i;
    assign wr_req    = accept_s & wb_we_i;
    assign wr_commit = wip_r & ~wr_term_r;

    // Pending flags span up to and including the termination cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rip_r     <= 1'b0;
            wip_r     <= 1'b0;
            wr_term_r <= 1'b0;
            resp_r    <= RESP_NONE;
        end else begin
            rip_r     <= rd_req;
            wip_r     <= wr_req | (wip_r & ~wr_term_r);
            wr_term_r <= wr_commit;
            if (rd_req) begin
                resp_r <= rd_resp;
            end else if (wr_commit) begin
                resp_r <= wr_resp;
            end else begin
                resp_r <= RESP_NONE;
            end
        end
    end

    assign wb_ack_o   = wb_cyc_i & (resp_r == RESP_ACK);
    assign wb_err_o   = wb_cyc_i & (resp_r == RESP_ERR);
    assign wb_stall_o = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);

endmodule

// File: rtl/wb_reg_bank_param.sv
// Parametrised Wishbone register bank: NUM_RW control words with byte-lane
// writes, NUM_RO status words, per-register strobes and optional bus error.
module wb_reg_bank_param
    import wb_reg_bank_pkg::*;
#(
    parameter int                  NUM_RW          = 4,
    parameter int                  NUM_RO          = 2,
    parameter int                  ADR_WIDTH       = 4,
    parameter logic [NUM_RW*32-1:0] RW_RESET       = {NUM_RW*32{1'b0}},
    parameter bit                  ERR_ON_UNMAPPED = 1'b1,
    localparam int                 RO_W            = (NUM_RO > 0) ? NUM_RO : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic [ADR_WIDTH-1:0]  wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_dat_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    output logic                  wb_stall_o,
    output logic [31:0]           wb_dat_o,
    output logic [NUM_RW*32-1:0]  rw_o,
    output logic [NUM_RW-1:0]     rw_wr_o,
    input  logic [RO_W*32-1:0]    ro_i,
    output logic [RO_W-1:0]       ro_rd_o
);

    if (NUM_RW < 1 || NUM_RO < 0 || ADR_WIDTH > DEC_AW || NUM_RW + NUM_RO > 2**ADR_WIDTH) begin : g_param_check
        $error("wb_reg_bank_param: illegal NUM_RW/NUM_RO/ADR_WIDTH combination");
    end

    dec_t                 dec_s;
    logic [31:0]          rd_data_s;
    logic [1:0]           miss_resp_s;
    logic [1:0]           rd_resp_s;
    logic [1:0]           wr_resp_s;
    logic                 rd_req_s;
    logic                 wr_req_s;
    logic                 wr_commit_s;
    logic                 wr_hit_r;
    logic [DEC_AW-1:0]    wr_idx_r;
    logic [31:0]          wr_dat_r;
    logic [3:0]           wr_sel_r;
    logic [NUM_RW*32-1:0] rw_r;
    logic [NUM_RW-1:0]    rw_wr_r;
    logic [RO_W-1:0]      ro_rd_r;
    logic [31:0]          dat_r;

    assign dec_s       = decode(DEC_AW'(wb_adr_i), NUM_RW, NUM_RO);
    assign miss_resp_s = ERR_ON_UNMAPPED ? RESP_ERR : RESP_ACK;
    assign rd_resp_s   = (dec_s.is_rw | dec_s.is_ro) ? RESP_ACK : miss_resp_s;
    // A zero-sel write to an RW word is still a legal access and gets ack.
    assign wr_resp_s   = wr_hit_r ? RESP_ACK : miss_resp_s;

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        for (int k = 0; k < NUM_RW; k++) begin
            rd_data_s = rd_data_s | ({32{dec_s.is_rw && dec_s.index == DEC_AW'(k)}} & rw_r[k*32 +: 32]);
        end
        for (int k = 0; k < NUM_RO; k++) begin
            rd_data_s = rd_data_s | ({32{dec_s.is_ro && dec_s.index == DEC_AW'(k)}} & ro_i[k*32 +: 32]);
        end
    end

    wb_pipe_slave_if u_pipe (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .rd_resp    (rd_resp_s),
        .wr_resp    (wr_resp_s),
        .rd_req     (rd_req_s),
        .wr_req     (wr_req_s),
        .wr_commit  (wr_commit_s),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_stall_o (wb_stall_o)
    );

    // Read data capture and RO read strobes, both visible in the cycle after acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dat_r   <= 32'h0000_0000;
            ro_rd_r <= {RO_W{1'b0}};
        end else begin
            if (rd_req_s) begin
                dat_r <= rd_data_s;
            end
            for (int k = 0; k < RO_W; k++) begin
                ro_rd_r[k] <= rd_req_s & dec_s.is_ro & (dec_s.index == DEC_AW'(k));
            end
        end
    end

    // Write capture on acceptance, commit one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_hit_r <= 1'b0;
            wr_idx_r <= {DEC_AW{1'b0}};
            wr_dat_r <= 32'h0000_0000;
            wr_sel_r <= 4'b0000;
            rw_r     <= RW_RESET;
            rw_wr_r  <= {NUM_RW{1'b0}};
        end else begin
            if (wr_req_s) begin
                wr_hit_r <= dec_s.is_rw;
                wr_idx_r <= dec_s.index;
                wr_dat_r <= wb_dat_i;
                wr_sel_r <= wb_sel_i;
            end
            for (int k = 0; k < NUM_RW; k++) begin
                if (wr_commit_s && wr_hit_r && wr_idx_r == DEC_AW'(k) && wr_sel_r != 4'b0000) begin
                    rw_r[k*32 +: 32] <= byte_merge(rw_r[k*32 +: 32], wr_dat_r, wr_sel_r);
                    rw_wr_r[k]       <= 1'b1;
                end else begin
                    rw_wr_r[k]       <= 1'b0;
                end
            end
        end
    end

    assign wb_rty_o = 1'b0;
    assign wb_dat_o = dat_r;
    assign rw_o     = rw_r;
    assign rw_wr_o  = rw_wr_r;
    assign ro_rd_o  = ro_rd_r;

endmodule

// File: tb/tb_wb_reg_bank_param.sv
// Self-checking bench for wb_reg_bank_param: directed table, randomized
// traffic against a word-level model, and cyc-drop / reset corner cases.
module tb_wb_reg_bank_param;

    localparam logic [127:0] RST_VAL = {32'h0000_0000, 32'h5A5A_0002, 32'h0000_0000, 32'hDEAD_BEEF};

    logic         clk = 1'b0;
    logic         rst;
    logic         cyc, stb, we;
    logic [3:0]   adr, sel;
    logic [31:0]  dat;
    logic [63:0]  ro_i;
    logic         ack_a, err_a, rty_a, stall_a, ack_b, err_b, rty_b, stall_b;
    logic [31:0]  dat_a, dat_b;
    logic [127:0] rw_o_a, rw_o_b;
    logic [3:0]   rw_wr_a, rw_wr_b;
    logic [1:0]   ro_rd_a, ro_rd_b;

    logic [31:0]  m_rw [4];
    logic [31:0]  m_ro [2];
    int           n_checks = 0;
    int           n_pass = 0;

    assign ro_i = {m_ro[1], m_ro[0]};

    always #5 clk = ~clk;

    wb_reg_bank_param #(.NUM_RW(4), .NUM_RO(2), .ADR_WIDTH(4), .RW_RESET(RST_VAL), .ERR_ON_UNMAPPED(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr), .wb_sel_i(sel),
        .wb_we_i(we), .wb_dat_i(dat), .wb_ack_o(ack_a), .wb_err_o(err_a), .wb_rty_o(rty_a),
        .wb_stall_o(stall_a), .wb_dat_o(dat_a), .rw_o(rw_o_a), .rw_wr_o(rw_wr_a), .ro_i(ro_i),
        .ro_rd_o(ro_rd_a));

    wb_reg_bank_param #(.NUM_RW(4), .NUM_RO(2), .ADR_WIDTH(4), .RW_RESET(RST_VAL), .ERR_ON_UNMAPPED(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr), .wb_sel_i(sel),
        .wb_we_i(we), .wb_dat_i(dat), .wb_ack_o(ack_b), .wb_err_o(err_b), .wb_rty_o(rty_b),
        .wb_stall_o(stall_b), .wb_dat_o(dat_b), .rw_o(rw_o_b), .rw_wr_o(rw_wr_b), .ro_i(ro_i),
        .ro_rd_o(ro_rd_b));

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] model_pack();
        return {m_rw[3], m_rw[2], m_rw[1], m_rw[0]};
    endfunction

    task automatic model_reset();
        logic [127:0] r;
        r = RST_VAL;
        for (int k = 0; k < 4; k++) m_rw[k] = r[32*k +: 32];
    endtask

    task automatic idle();
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // One request held until termination; returns after the terminating cycle's negedge.
    task automatic bus_op(input logic op_we, input logic [3:0] op_adr, input logic [31:0] op_dat,
                          input logic [3:0] op_sel, output logic got_err, output logic [31:0] got_dat);
        logic map_rw, map_ro, ok, stray;
        int lat, term_c;
        logic [3:0] exp_wr;
        logic [1:0] exp_rd;
        logic [31:0] exp_dat;
        logic [127:0] old_rw;
        map_rw  = op_adr < 4'd4;
        map_ro  = (op_adr >= 4'd4) && (op_adr < 4'd6);
        ok      = op_we ? map_rw : (map_rw | map_ro);
        lat     = op_we ? 2 : 1;
        exp_wr  = (op_we && map_rw && op_sel != 4'b0000) ? (4'b0001 << op_adr[1:0]) : 4'b0000;
        exp_rd  = (!op_we && map_ro) ? (2'b01 << op_adr[0]) : 2'b00;
        exp_dat = map_rw ? m_rw[op_adr[1:0]] : (map_ro ? m_ro[op_adr[0]] : 32'h0);
        old_rw  = model_pack();
        if (op_we && map_rw)
            for (int b = 0; b < 4; b++)
                if (op_sel[b]) m_rw[op_adr[1:0]][8*b +: 8] = op_dat[8*b +: 8];
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = op_we; adr = op_adr; dat = op_dat; sel = op_sel;
        term_c = -1; stray = 1'b0; got_err = 1'b0; got_dat = 32'h0;
        for (int c = 0; c < 6 && term_c < 0; c++) begin
            @(negedge clk);
            if (ack_a && err_a) stray = 1'b1;
            if (c == 0) check("stall_at_accept", stall_a, 1'b1);
            if (c == 1 && op_we) check("rw_o_before_commit", rw_o_a, old_rw);
            if (c == lat) begin
                check("rw_wr_o", rw_wr_a, exp_wr);
                check("ro_rd_o", ro_rd_a, exp_rd);
                check("rw_o", rw_o_a, model_pack());
            end else if (rw_wr_a != 4'b0000 || ro_rd_a != 2'b00) begin
                stray = 1'b1;
            end
            if (ack_a || err_a) begin
                term_c  = c;
                got_err = err_a;
                got_dat = dat_a;
                check("resp_err_on", {ack_a, err_a}, ok ? 2'b10 : 2'b01);
                check("resp_err_off", {ack_b, err_b}, 2'b10);
                check("stall_at_term", stall_a, 1'b0);
            end
        end
        check("latency", 128'(term_c), 128'(lat));
        check("stray_pulse", stray, 1'b0);
        if (!op_we) check("rd_data", got_dat, exp_dat);
    endtask

    initial begin
        vec_t        tbl [12];
        logic        e;
        logic [31:0] d;

        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [12];
        logic        e;
        logic [31:0] d;

        tbl[0]  = '{1'b0, 4'h0, 32'h0,          4'hF, 1'b0, 32'hDEAD_BEEF};
        tbl[1]  = '{1'b1, 4'h1, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 4'h1, 32'h0,          4'hF, 1'b0, 32'h1234_5678};
        tbl[3]  = '{1'b1, 4'h1, 32'hAABB_CCDD, 4'h4, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 4'h1, 32'h0,          4'hF, 1'b0, 32'h12BB_5678};
        tbl[5]  = '{1'b1, 4'h1, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 4'h1, 32'h0,          4'hF, 1'b0, 32'h12BB_5678};
        tbl[7]  = '{1'b0, 4'h4, 32'h0,          4'hF, 1'b0, 32'hCAFE_F00D};
        tbl[8]  = '{1'b1, 4'h5, 32'h1111_2222, 4'hF, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 4'hF, 32'h0,          4'hF, 1'b1, 32'h0};
        tbl[10] = '{1'b1, 4'hF, 32'h3333_4444, 4'hF, 1'b1, 32'h0};
        tbl[11] = '{1'b0, 4'h5, 32'h0,          4'hF, 1'b0, 32'h0BAD_C0DE};

        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 4'h0; sel = 4'h0; dat = 32'h0;
        m_ro[0] = 32'hCAFE_F00D; m_ro[1] = 32'h0BAD_C0DE;
        model_reset();

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check("reset_rw_o", rw_o_a, RST_VAL);
        check("reset_resp", {ack_a, err_a, rty_a, stall_a}, 4'b0000);
        check("reset_dat", dat_a, 32'h0);
        check("reset_strobes", {rw_wr_a, ro_rd_a}, 6'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            bus_op(tbl[i].we, tbl[i].adr, tbl[i].wdat, tbl[i].sel, e, d);
            check($sformatf("tbl%0d_err", i), e, tbl[i].exp_err);
            if (!tbl[i].we) check($sformatf("tbl%0d_dat", i), d, tbl[i].exp_rd);
        end
        idle();

        // cyc dropped after acceptance: write still commits, no termination seen
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'h3; dat = 32'h7654_3210; sel = 4'hF;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("cycdrop_n1_resp", {ack_a, err_a}, 2'b00);
        @(negedge clk);
        m_rw[3] = 32'h7654_3210;
        check("cycdrop_n2_resp", {ack_a, err_a}, 2'b00);
        check("cycdrop_rw_wr", rw_wr_a, 4'b1000);
        check("cycdrop_rw_o", rw_o_a, model_pack());
        bus_op(1'b0, 4'h3, 32'h0, 4'hF, e, d);
        idle();

        // Reset during cycle N+1 of a write
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'h2; dat = 32'h0F0F_0F0F; sel = 4'hF;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst_rw_o", rw_o_a, RST_VAL);
        check("midrst_resp", {ack_a, err_a}, 2'b00);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("midrst_hold", {ack_a, err_a, rw_wr_a}, 6'b0);
        #2 rst = 1'b0;
        bus_op(1'b1, 4'h2, 32'h89AB_CDEF, 4'hF, e, d);
        bus_op(1'b0, 4'h2, 32'h0, 4'hF, e, d);
        check("midrst_readback", d, 32'h89AB_CDEF);
        idle();

        // Randomized traffic, mixing back-to-back and idle gaps
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) m_ro[$urandom_range(0, 1)] = $urandom;
            if ($urandom_range(0, 4) == 0) idle();
            bus_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                   4'($urandom_range(0, 15)), e, d);
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
